stream_reorder_buf: RTL
=======================

STREAM_REORDER_BUF -- requirements
Module: stream_reorder_buf

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, sample width in bits.
REQ-002 SHALL provide parameter N_PTS, default 8, frame length in samples; power of two, 4..1024; LOG2N derived internally.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port in_data  input  DATA_W  input sample, natural order.
REQ-006 SHALL provide port in_valid  input  1  in_data valid.
REQ-007 SHALL provide port in_ready  output  1  block can accept a sample this cycle.
REQ-008 SHALL provide port out_data  output  DATA_W  reordered sample, registered.
REQ-009 SHALL provide port out_valid  output  1  out_data valid, registered.
REQ-010 SHALL provide port out_ready  input  1  downstream accepts out_data.
REQ-011 SHALL provide port out_last  output  1  high with the final sample (index N_PTS-1) of each output frame.

Function
REQ-012 SHALL hold two banks (ping-pong) of N_PTS x DATA_W registers; each bank has a full flag.
REQ-013 Input transfer SHALL occur on in_valid && in_ready; sample written to write bank at wr_idx, wr_idx increments.
REQ-014 On transfer at wr_idx = N_PTS-1: wr_idx wraps to 0, write bank marked full, write bank pointer toggles.
REQ-015 in_ready SHALL be low iff the bank addressed by the write pointer is full; combinational from registered flags only.
REQ-016 Output register SHALL load when (out_valid==0 || out_ready==1) and read bank is full; loads bank[perm(rd_idx)], rd_idx increments.
REQ-017 On load with rd_idx = N_PTS-1: out_last set with that sample, rd_idx wraps, read bank full flag cleared, read pointer toggles.
REQ-018 If output register advances with no full read bank, out_valid SHALL drop to 0.
REQ-019 While out_valid && !out_ready, out_data, out_valid and out_last SHALL hold stable.
REQ-020 Latency: first output of a frame SHALL be valid the cycle after its last input transfer, when the read side is idle.
REQ-021 Throughput: with in_valid and out_ready held high, SHALL sustain one sample per cycle on both ports, no bubbles between frames.
REQ-022 Simultaneous bank-fill (write side) and bank-release (read side) in one cycle SHALL both take effect; in_ready is not dropped.
REQ-023 A bank SHALL not be rewritten until its last sample has been loaded into the output register.
REQ-024 No data width change: out_data SHALL equal the stored sample bit-exactly.

Reset
REQ-025 rst_n low SHALL immediately clear: out_valid=0, out_last=0, out_data=0, both full flags, wr_idx=0, rd_idx=0, both bank pointers=0.
REQ-026 Bank storage SHALL not be reset; partial and pending frames are discarded on reset mid-operation.
REQ-027 in_ready SHALL be 1 from the first cycle after rst_n deasserts.

Configuration
REQ-028 Macro REORDER_BITREV_EN defined: perm(k) = bit-reverse of k over LOG2N bits (full radix-2 DIT input ordering).
REQ-029 Macro REORDER_BITREV_EN undefined: single even/odd split; perm(k) = 2k for k < N_PTS/2, 2(k-N_PTS/2)+1 otherwise.

Verification
REQ-030 N_PTS=8, macro undefined, inputs 0..7 back-to-back, out_ready=1 -> outputs 0,2,4,6,1,3,5,7, out_last on 7, first output cycle after input 7.
REQ-031 N_PTS=8, macro defined, inputs 0..7 -> outputs 0,4,2,6,1,5,3,7; N_PTS=16 inputs 0..15 -> 0,8,4,12,...,15.
REQ-032 Three frames continuous, out_ready=1 -> in_ready never low, 24 outputs on consecutive cycles.
REQ-033 out_ready=0 throughout, 20 input offers -> exactly 16 accepted, in_ready low afterwards, out_data stable at the frame's first sample.
REQ-034 Random out_ready 50% and in_valid 50% over 100 frames -> outputs match permutation model, no loss or duplication.
REQ-035 rst_n asserted after 5 inputs of frame and mid-output of prior frame -> out_valid=0 asynchronously; next frame 0..7 reorders correctly.

Source files
------------

// File: rtl/stream_reorder_buf.sv
// stream_reorder_buf: ping-pong frame buffer that reorders each N_PTS-sample
// frame for a radix-2 FFT front end.
//   Ports: clk, rst_n (async, active-low)
//          in_data/in_valid/in_ready    natural-order input stream
//          out_data/out_valid/out_ready reordered output stream (registered)
//          out_last                     marks sample N_PTS-1 of each frame
//   Macro REORDER_BITREV_EN: defined -> full bit-reverse ordering,
//                            undefined -> single even/odd split.
module stream_reorder_buf #(
    parameter int DATA_W = 8,
    parameter int N_PTS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int LOG2N = $clog2(N_PTS);
    localparam logic [LOG2N-1:0] IDX_MAX = LOG2N'(N_PTS - 1);

    logic [DATA_W-1:0] bank [2][N_PTS];
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [LOG2N-1:0]  wr_idx;
    logic [LOG2N-1:0]  rd_idx;

    logic wr_fire;
    logic wr_last;
    logic adv;
    logic avail;
    logic rd_fire;
    logic rd_last;

    function automatic logic [LOG2N-1:0] perm(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        r = '0;
`ifdef REORDER_BITREV_EN
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = k[LOG2N-1-b];
        end
`else
        // Rotate-left by one: low half -> 2k, high half -> 2(k-N/2)+1.
        r = {k[LOG2N-2:0], k[LOG2N-1]};
`endif
        return r;
    endfunction

    assign in_ready = !full[wr_ptr];
    assign wr_fire  = in_valid && in_ready;
    assign wr_last  = wr_fire && (wr_idx == IDX_MAX);
    assign adv      = !out_valid || out_ready;

    // perm(0) is 0 in both orderings, and that sample is already stored
    // when the final write lands, so an idle read side may start the frame
    // on the same edge the bank fills.
    assign avail   = full[rd_ptr] || (wr_last && (wr_ptr == rd_ptr));
    assign rd_fire = adv && avail;
    assign rd_last = rd_fire && (rd_idx == IDX_MAX);

    // A filling bank and a draining bank are always different banks, so
    // both updates can apply in the same cycle.
    always_comb begin
        full_nxt = full;
        if (wr_last) full_nxt[wr_ptr] = 1'b1;
        if (rd_last) full_nxt[rd_ptr] = 1'b0;
    end

    // Storage has no reset.
    always_ff @(posedge clk) begin
        if (wr_fire) bank[wr_ptr][wr_idx] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_idx <= wr_idx + 1'b1;
                if (wr_last) wr_ptr <= !wr_ptr;
            end
            if (rd_fire) begin
                rd_idx <= rd_idx + 1'b1;
                if (rd_last) rd_ptr <= !rd_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (rd_fire) begin
            out_data  <= bank[rd_ptr][perm(rd_idx)];
            out_valid <= 1'b1;
            out_last  <= rd_last;
        end else if (adv) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
